// File: rtl/id_branch_stage.sv
// id_branch_stage: decodes the instruction, extends the immediate, resolves branches and jumps, and tags delay slots.
// Latency: 1 cycle from xfer (in_valid & in_ready) to out_valid. Redirect pulses for one cycle alongside a taken branch/jump.
// Backpressure: out_valid & ~out_ready holds every output and the slot FSM, and drops in_ready.
// Build option: define ID_BRANCH_LIKELY_EN to decode beql/bnel and nullify the delay slot when they are not taken.
module id_branch_stage #(
   parameter int XLEN   = 32,
   parameter int EXC_W  = 5,
   parameter int EXC_RI = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc4,
   input  logic [XLEN-1:0]  rs_val,
   input  logic [XLEN-1:0]  rt_val,
   input  logic             exc_in,
   input  logic [EXC_W-1:0] exc_code_in,
   input  logic [XLEN-1:0]  epc_in,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [31:0]      out_inst,
   output logic [XLEN-1:0]  out_rs,
   output logic [XLEN-1:0]  out_rt,
   output logic [XLEN-1:0]  out_imm,
   output logic [XLEN-1:0]  out_link,
   output logic             out_exc,
   output logic [EXC_W-1:0] out_exc_code,
   output logic [XLEN-1:0]  out_epc,
   output logic             out_bd,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_target
);

`ifdef ID_BRANCH_LIKELY_EN
   localparam bit BL_EN = 1'b1;
`else
   localparam bit BL_EN = 1'b0;
`endif

   localparam logic [31:0] ERET_WORD = 32'h4200_0018;

   typedef enum logic [1:0] {
      ST_NORMAL    = 2'd0,
      ST_SLOT      = 2'd1,
      ST_SLOT_NULL = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [5:0] op, funct;
   logic [4:0] rt_f;
   assign op    = inst[31:26];
   assign funct = inst[5:0];
   assign rt_f  = inst[20:16];

   logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez, is_beql, is_bnel;
   logic is_j, is_jal, is_jr, is_jalr, is_eret, is_lui, is_zext, ri_op;
   logic is_ctrl, is_likely, taken;
   logic rs_neg, rs_zero, ops_eq;
   logic in_slot, ri, clean, xfer;
   logic [XLEN-1:0] sext_imm, imm_d, br_tgt, j_tgt, tgt_d;

   // Output-stage state and next values
   logic             out_valid_q, redirect_q, out_exc_q, out_bd_q;
   logic [31:0]      out_inst_q;
   logic [XLEN-1:0]  out_rs_q, out_rt_q, out_imm_q, out_link_q, out_epc_q, redirect_target_q;
   logic [EXC_W-1:0] out_exc_code_q;
   logic             exc_d, bd_d, redirect_d;
   logic [31:0]      inst_d;
   logic [EXC_W-1:0] code_d;

   assign in_ready = ~out_valid_q | out_ready;
   assign xfer     = in_valid & in_ready;

   // Opcode classification; anything not listed is a reserved instruction
   always_comb begin
      is_beq  = 1'b0; is_bne  = 1'b0; is_blez = 1'b0; is_bgtz = 1'b0;
      is_bltz = 1'b0; is_bgez = 1'b0; is_beql = 1'b0; is_bnel = 1'b0;
      is_j    = 1'b0; is_jal  = 1'b0; is_jr   = 1'b0; is_jalr = 1'b0;
      is_eret = 1'b0; is_lui  = 1'b0; is_zext = 1'b0; ri_op   = 1'b0;
      case (op)
         6'h00: begin
            if (funct == 6'h08)      is_jr   = 1'b1;
            else if (funct == 6'h09) is_jalr = 1'b1;
         end
         6'h01: begin
            if (rt_f == 5'd0)      is_bltz = 1'b1;
            else if (rt_f == 5'd1) is_bgez = 1'b1;
            else                   ri_op   = 1'b1;
         end
         6'h02: is_j    = 1'b1;
         6'h03: is_jal  = 1'b1;
         6'h04: is_beq  = 1'b1;
         6'h05: is_bne  = 1'b1;
         6'h06: is_blez = 1'b1;
         6'h07: is_bgtz = 1'b1;
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
         6'h28, 6'h29, 6'h2B: begin
            // sign-extended I-type, nothing further to flag
         end
         6'h0C, 6'h0D, 6'h0E: is_zext = 1'b1;
         6'h0F: is_lui = 1'b1;
         6'h10: begin
            if (inst == ERET_WORD) is_eret = 1'b1;
            else                   ri_op   = 1'b1;
         end
         6'h14: begin
            if (BL_EN) is_beql = 1'b1;
            else       ri_op   = 1'b1;
         end
         6'h15: begin
            if (BL_EN) is_bnel = 1'b1;
            else       ri_op   = 1'b1;
         end
         default: ri_op = 1'b1;
      endcase
   end

   // Signed operand compares, branch resolution and target selection
   always_comb begin
      rs_neg    = rs_val[XLEN-1];
      rs_zero   = (rs_val == '0);
      ops_eq    = (rs_val == rt_val);
      is_likely = is_beql | is_bnel;
      is_ctrl   = is_beq | is_bne | is_blez | is_bgtz | is_bltz | is_bgez | is_likely
                | is_j | is_jal | is_jr | is_jalr;
      taken     = ((is_beq | is_beql) & ops_eq) | ((is_bne | is_bnel) & ~ops_eq)
                | (is_blez & (rs_neg | rs_zero)) | (is_bgtz & ~(rs_neg | rs_zero))
                | (is_bltz & rs_neg) | (is_bgez & ~rs_neg)
                | is_j | is_jal | is_jr | is_jalr;
      sext_imm  = {{(XLEN-16){inst[15]}}, inst[15:0]};
      br_tgt    = pc4 + (sext_imm << 2);
      j_tgt     = {pc4[XLEN-1:28], inst[25:0], 2'b00};
      if (is_jr | is_jalr)    tgt_d = rs_val;
      else if (is_j | is_jal) tgt_d = j_tgt;
      else                    tgt_d = br_tgt;
      if (is_lui)       imm_d = sext_imm << 16;
      else if (is_zext) imm_d = {{(XLEN-16){1'b0}}, inst[15:0]};
      else              imm_d = sext_imm;
   end

   // A control transfer inside a delay slot is illegal and reported as reserved
   assign in_slot = (state_q != ST_NORMAL);
   assign ri      = ri_op | (in_slot & (is_ctrl | is_eret));
   assign clean   = ~exc_in & ~ri;

   // Delay-slot FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_NORMAL;
      else          state_q <= state_d;
   end

   // Delay-slot FSM next state: flush wins, otherwise only an accepted instruction moves it
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_NORMAL;
      end else if (xfer) begin
         if (in_slot)                         state_d = ST_NORMAL;
         else if (clean & is_eret)            state_d = ST_SLOT_NULL;
         else if (clean & is_likely & ~taken) state_d = ST_SLOT_NULL;
         else if (clean & is_ctrl)            state_d = ST_SLOT;
         else                                 state_d = ST_NORMAL;
      end
   end

   // Delay-slot FSM outputs: slot tagging, nullification, exception merge, redirect request
   always_comb begin
      bd_d       = in_slot;
      inst_d     = (state_q == ST_SLOT_NULL) ? 32'h0 : inst;
      exc_d      = (state_q != ST_SLOT_NULL) & (exc_in | ri);
      code_d     = '0;
      if (state_q != ST_SLOT_NULL) begin
         if (exc_in)  code_d = exc_code_in;
         else if (ri) code_d = EXC_W'(EXC_RI);
      end
      redirect_d = ~in_slot & clean & is_ctrl & taken;
   end

   // Output register: load on xfer, drain on out_ready, flush kills valid and redirect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q       <= 1'b0;
         redirect_q        <= 1'b0;
         out_inst_q        <= '0;
         out_rs_q          <= '0;
         out_rt_q          <= '0;
         out_imm_q         <= '0;
         out_link_q        <= '0;
         out_exc_q         <= 1'b0;
         out_exc_code_q    <= '0;
         out_epc_q         <= '0;
         out_bd_q          <= 1'b0;
         redirect_target_q <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         redirect_q  <= 1'b0;
      end else if (xfer) begin
         out_valid_q       <= 1'b1;
         redirect_q        <= redirect_d;
         out_inst_q        <= inst_d;
         out_rs_q          <= rs_val;
         out_rt_q          <= rt_val;
         out_imm_q         <= imm_d;
         out_link_q        <= pc4 + XLEN'(4);
         out_exc_q         <= exc_d;
         out_exc_code_q    <= code_d;
         out_epc_q         <= epc_in;
         out_bd_q          <= bd_d;
         redirect_target_q <= tgt_d;
      end else begin
         redirect_q <= 1'b0;
         if (out_ready) out_valid_q <= 1'b0;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_inst        = out_inst_q;
   assign out_rs          = out_rs_q;
   assign out_rt          = out_rt_q;
   assign out_imm         = out_imm_q;
   assign out_link        = out_link_q;
   assign out_exc         = out_exc_q;
   assign out_exc_code    = out_exc_code_q;
   assign out_epc         = out_epc_q;
   assign out_bd          = out_bd_q;
   assign redirect        = redirect_q;
   assign redirect_target = redirect_target_q;

endmodule

// File: tb/tb_id_branch_stage.sv
// Bench for id_branch_stage: constant vector table, directed multi-cycle sequences,
// and a random run against a reference model built from the instruction semantics.
module tb_id_branch_stage;

`ifdef ID_BRANCH_LIKELY_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   localparam logic [31:0] ADDU = 32'h0022_1821;

   logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, exc_in = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] inst = '0, pc4 = '0, rs_val = '0, rt_val = '0, epc_in = '0;
   logic [4:0]  exc_code_in = '0;
   logic        in_ready, out_valid, out_exc, out_bd, redirect;
   logic [31:0] out_inst, out_rs, out_rt, out_imm, out_link, out_epc, redirect_target;
   logic [4:0]  out_exc_code;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   id_branch_stage #(.XLEN(32), .EXC_W(5), .EXC_RI(10)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc4(pc4), .rs_val(rs_val), .rt_val(rt_val),
      .exc_in(exc_in), .exc_code_in(exc_code_in), .epc_in(epc_in), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst),
      .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm), .out_link(out_link),
      .out_exc(out_exc), .out_exc_code(out_exc_code), .out_epc(out_epc),
      .out_bd(out_bd), .redirect(redirect), .redirect_target(redirect_target)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] inst, rs, rt, imm, link, epc, target;
      logic        exc, bd, redirect;
      logic [4:0]  code;
      int          nxt;   // slot mode after this instruction: 0 none, 1 slot, 2 nullified slot
   } pred_t;

   function automatic pred_t predict(input logic [31:0] i, input logic [31:0] p4, input logic [31:0] a,
                                     input logic [31:0] b, input logic ein, input logic [4:0] ecode,
                                     input logic [31:0] epc, input int mode);
      pred_t p;
      int op, fn, sub, sa, sb;
      bit res, ctrl, eret, likely, tk, zext, lui, ok;
      logic [31:0] simm, brt;
      op = int'(i[31:26]); fn = int'(i[5:0]); sub = int'(i[20:16]);
      sa = $signed(a); sb = $signed(b);
      res = 0; ctrl = 0; eret = 0; likely = 0; tk = 0; zext = 0; lui = 0;
      simm = {{16{i[15]}}, i[15:0]};
      brt  = p4 + simm * 4;
      p.target = brt;
      case (op)
         0:  if (fn == 8 || fn == 9) begin ctrl = 1; tk = 1; p.target = a; end
         1:  if (sub == 0)      begin ctrl = 1; tk = (sa < 0); end
             else if (sub == 1) begin ctrl = 1; tk = (sa >= 0); end
             else res = 1;
         2, 3: begin ctrl = 1; tk = 1; p.target = {p4[31:28], i[25:0], 2'b00}; end
         4:  begin ctrl = 1; tk = (sa == sb); end
         5:  begin ctrl = 1; tk = (sa != sb); end
         6:  begin ctrl = 1; tk = (sa <= 0); end
         7:  begin ctrl = 1; tk = (sa > 0); end
         8, 9, 10, 11, 32, 33, 35, 36, 37, 40, 41, 43: ;
         12, 13, 14: zext = 1;
         15: lui = 1;
         16: if (i == 32'h4200_0018) eret = 1; else res = 1;
         20, 21: if (BL) begin ctrl = 1; likely = 1; tk = (op == 20) ? (sa == sb) : (sa != sb); end
                 else res = 1;
         default: res = 1;
      endcase
      if (mode != 0 && (ctrl || eret)) res = 1;
      ok = !ein && !res;
      p.redirect = (mode == 0) && ok && ctrl && tk;
      if (mode != 0 || !ok)      p.nxt = 0;
      else if (eret)             p.nxt = 2;
      else if (likely && !tk)    p.nxt = 2;
      else if (ctrl)             p.nxt = 1;
      else                       p.nxt = 0;
      p.bd   = (mode != 0);
      p.inst = (mode == 2) ? 32'h0 : i;
      p.exc  = (mode == 2) ? 1'b0 : (ein || res);
      p.code = (mode == 2) ? 5'd0 : ein ? ecode : res ? 5'd10 : 5'd0;
      p.imm  = lui ? {i[15:0], 16'h0} : zext ? {16'h0, i[15:0]} : simm;
      p.link = p4 + 4;
      p.rs = a; p.rt = b; p.epc = epc;
      return p;
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 17))
         0:  begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
         1:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
         2:  begin r[31:26] = 6'h00; r[5:0] = 6'h09; end
         3:  begin r[31:26] = 6'h01; r[20:16] = 5'($urandom_range(0, 2)); end
         4:  r[31:26] = 6'h04;
         5:  r[31:26] = 6'h05;
         6:  r[31:26] = 6'h06;
         7:  r[31:26] = 6'h07;
         8:  r[31:26] = 6'h02;
         9:  r[31:26] = 6'h03;
         10: r[31:26] = 6'h09;
         11: r[31:26] = 6'h0D;
         12: r[31:26] = 6'h0F;
         13: r[31:26] = 6'h23;
         14: r[31:26] = 6'h14;
         15: r[31:26] = 6'h15;
         16: r = 32'h4200_0018;
         default: r[31:26] = 6'($urandom_range(48, 63));
      endcase
      return r;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] inst, pc4, rs, rt;
      logic        ein;
      logic [4:0]  ecode;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] imm;
      logic        redir;
      logic [31:0] tgt;
      int          nxt;
   } vec_t;

   vec_t vt[$];

   task automatic add(input string n, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic ei, input logic [4:0] ec, input logic x,
                      input logic [4:0] c, input logic [31:0] im, input logic rd, input logic [31:0] t,
                      input int nx);
      vec_t v;
      v.name = n; v.inst = i; v.pc4 = p; v.rs = a; v.rt = b; v.ein = ei; v.ecode = ec;
      v.exc = x; v.code = c; v.imm = im; v.redir = rd; v.tgt = t; v.nxt = nx;
      vt.push_back(v);
   endtask

   pred_t m_out;
   logic  m_valid, m_redir;
   int    m_mode, redir_cnt;

   initial begin
      add("beq_taken",  32'h1022_0003, 32'h3004, 32'd5, 32'd5, 0, 0, 0, 0, 32'h3,         1, 32'h3010, 1);
      add("bne_nt",     32'h1422_FFFF, 32'h0400, 32'd7, 32'd7, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0,        1);
      add("bne_taken",  32'h1422_FFFE, 32'h0100, 32'd1, 32'd2, 0, 0, 0, 0, 32'hFFFF_FFFE, 1, 32'h00F8,  1);
      add("blez_zero",  32'h1820_0004, 32'h0200, 32'd0, 32'd9, 0, 0, 0, 0, 32'h4,         1, 32'h0210,  1);
      add("bgtz_zero",  32'h1C20_0004, 32'h0200, 32'd0, 32'd9, 0, 0, 0, 0, 32'h4,         0, 0,        1);
      add("bltz_neg",   32'h0420_0010, 32'h1000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h10,     1, 32'h1040,  1);
      add("bgez_neg",   32'h0421_0010, 32'h1000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h10,     0, 0,        1);
      add("bgtz_max",   32'h1C20_0001, 32'h0010, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 32'h1,      1, 32'h0014,  1);
      add("j_region",   32'h0800_0100, 32'h9000_0004, 0, 0, 0, 0, 0, 0, 32'h100,           1, 32'h9000_0400, 1);
      add("jr",         32'h0020_0008, 32'h0050, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h8,      1, 32'h1234_5678, 1);
      add("lui",        32'h3C01_ABCD, 32'h0060, 0, 0, 0, 0, 0, 0, 32'hABCD_0000,          0, 0,        0);
      add("ori_zext",   32'h3421_8001, 32'h0060, 0, 0, 0, 0, 0, 0, 32'h0000_8001,          0, 0,        0);
      add("addiu_sext", 32'h2421_8001, 32'h0060, 0, 0, 0, 0, 0, 0, 32'hFFFF_8001,          0, 0,        0);
      add("ri_3f",      32'hFC00_0000, 32'h0070, 0, 0, 0, 0, 1, 10, 32'h0,                 0, 0,        0);
      add("ri_3f_exc",  32'hFC00_0000, 32'h0070, 0, 0, 1, 4, 1, 4, 32'h0,                  0, 0,        0);
      add("beq_exc",    32'h1022_0003, 32'h3004, 32'd5, 32'd5, 1, 4, 1, 4, 32'h3,          0, 0,        0);
      add("regimm_ri",  32'h0422_0000, 32'h0080, 0, 0, 0, 0, 1, 10, 32'h0,                 0, 0,        0);
      add("eret",       32'h4200_0018, 32'h0090, 0, 0, 0, 0, 0, 0, 32'h18,                 0, 0,        2);
      if (BL) begin
         add("beql_taken", 32'h5022_0003, 32'h3004, 32'd5, 32'd5, 0, 0, 0, 0, 32'h3, 1, 32'h3010, 1);
         add("bnel_nt",    32'h5422_0003, 32'h3004, 32'd5, 32'd5, 0, 0, 0, 0, 32'h3, 0, 0,        2);
      end else begin
         add("beql_ri",    32'h5022_0003, 32'h3004, 32'd5, 32'd5, 0, 0, 1, 10, 32'h3, 0, 0, 0);
         add("bnel_ri",    32'h5422_0003, 32'h3004, 32'd5, 32'd5, 0, 0, 1, 10, 32'h3, 0, 0, 0);
      end

      // Reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_bundle", {out_inst, out_link, out_imm}, 0);
      chk("rst_flags", {out_exc, out_exc_code, out_bd, redirect_target}, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;

      // Table: each vector from NORMAL, then an addu to observe the slot tagging
      for (int i = 0; i < vt.size(); i++) begin
         inst = vt[i].inst; pc4 = vt[i].pc4; rs_val = vt[i].rs; rt_val = vt[i].rt;
         exc_in = vt[i].ein; exc_code_in = vt[i].ecode; epc_in = 32'hE000_0000 + i;
         in_valid = 1'b1;
         tick();
         chk({vt[i].name, "_valid"}, out_valid, 1);
         chk({vt[i].name, "_exc"}, {out_exc, out_exc_code}, {vt[i].exc, vt[i].code});
         chk({vt[i].name, "_imm"}, out_imm, vt[i].imm);
         chk({vt[i].name, "_redirect"}, redirect, vt[i].redir);
         if (vt[i].redir) chk({vt[i].name, "_target"}, redirect_target, vt[i].tgt);
         chk({vt[i].name, "_link_epc"}, {out_link, out_epc}, {vt[i].pc4 + 32'd4, 32'hE000_0000 + i});
         inst = ADDU; exc_in = 1'b0; exc_code_in = '0;
         tick();
         chk({vt[i].name, "_slot_bd"}, out_bd, vt[i].nxt != 0);
         chk({vt[i].name, "_slot_inst"}, out_inst, (vt[i].nxt == 2) ? 32'h0 : ADDU);
         chk({vt[i].name, "_slot_redirect"}, redirect, 0);
         in_valid = 1'b0;
         tick();
      end

      // Backpressure: jal held for three cycles, redirect pulses once
      inst = 32'h0C00_0040; pc4 = 32'h3008; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      redir_cnt = int'(redirect);
      chk("bp_first", {out_valid, redirect, in_ready}, 3'b110);
      chk("bp_target", redirect_target, 32'h100);
      inst = ADDU; pc4 = 32'h300C;
      for (int k = 0; k < 2; k++) begin
         tick();
         redir_cnt += int'(redirect);
         chk("bp_hold", {out_valid, in_ready, out_link, out_inst}, {2'b10, 32'h300C, 32'h0C00_0040});
      end
      out_ready = 1'b1;
      tick();
      redir_cnt += int'(redirect);
      chk("bp_slot", {out_inst, out_bd}, {ADDU, 1'b1});
      chk("bp_redirect_count", redir_cnt, 1);
      in_valid = 1'b0;
      tick();

`ifdef ID_BRANCH_LIKELY_EN
      // Likely branch not taken nullifies its slot, even one carrying an exception
      inst = 32'h5422_0003; pc4 = 32'h0500; rs_val = 32'd3; rt_val = 32'd3; in_valid = 1'b1;
      tick();
      chk("bl_no_redirect", redirect, 0);
      inst = ADDU; exc_in = 1'b1; exc_code_in = 5'd4;
      tick();
      chk("bl_null_slot", {out_inst, out_bd, out_exc}, {32'h0, 2'b10});
      exc_in = 1'b0; in_valid = 1'b0;
      tick();
`endif

      // Flush in the same cycle as the delay-slot xfer after jr
      inst = 32'h0020_0008; rs_val = 32'h4000; in_valid = 1'b1;
      tick();
      chk("fr_redirect", {redirect, redirect_target}, {1'b1, 32'h4000});
      inst = ADDU; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fr_dropped", {out_valid, redirect}, 2'b00);
      tick();
      chk("fr_after", {out_valid, out_bd}, 2'b10);
      in_valid = 1'b0;
      tick();

      // Branch inside a delay slot is reserved and does not redirect
      inst = 32'h0020_0008; rs_val = 32'h5000; rt_val = 32'h5000; in_valid = 1'b1;
      tick();
      inst = 32'h1022_0003;
      tick();
      chk("slot_br_ri", {out_exc, out_exc_code, out_bd, redirect}, {1'b1, 5'd10, 1'b1, 1'b0});
      inst = ADDU;
      tick();
      chk("slot_br_after_bd", out_bd, 0);
      in_valid = 1'b0;
      tick();

      // Reset while a taken branch sits in the output register
      inst = 32'h1022_0003; pc4 = 32'h3004; rs_val = 32'd5; rt_val = 32'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_outputs", {out_valid, redirect, out_bd, out_exc, out_inst, out_link, redirect_target}, 0);
      tick();
      reset_n = 1'b1;
      #1;
      chk("mrst_in_ready", in_ready, 1);
      inst = ADDU; in_valid = 1'b1;
      tick();
      chk("mrst_bd", {out_valid, out_bd}, 2'b10);
      in_valid = 1'b0;
      tick();

      // Random run against the reference model
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      m_valid = 1'b0; m_redir = 1'b0; m_mode = 0;
      m_out = predict(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 0);
      for (int c = 0; c < 3000; c++) begin
         logic rdy;
         pred_t p;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 29) == 0);
         inst      = rnd_inst();
         pc4       = $urandom();
         case ($urandom_range(0, 3))
            0:       rs_val = 32'h0;
            1:       rs_val = 32'hFFFF_FFFF;
            default: rs_val = $urandom();
         endcase
         rt_val      = ($urandom_range(0, 2) == 0) ? $urandom() : rs_val;
         exc_in      = ($urandom_range(0, 19) == 0);
         exc_code_in = 5'($urandom());
         epc_in      = $urandom();
         rdy = !m_valid || out_ready;
         #1;
         chk("rnd_in_ready", in_ready, rdy);
         if (flush) begin
            m_valid = 1'b0; m_redir = 1'b0; m_mode = 0;
         end else if (in_valid && rdy) begin
            p = predict(inst, pc4, rs_val, rt_val, exc_in, exc_code_in, epc_in, m_mode);
            m_out = p; m_valid = 1'b1; m_redir = p.redirect; m_mode = p.nxt;
         end else begin
            m_redir = 1'b0;
            if (out_ready) m_valid = 1'b0;
         end
         tick();
         chk("rnd_valid_redirect", {out_valid, redirect}, {m_valid, m_redir});
         if (m_valid) begin
            chk("rnd_inst_imm", {out_inst, out_imm}, {m_out.inst, m_out.imm});
            chk("rnd_operands", {out_rs, out_rt}, {m_out.rs, m_out.rt});
            chk("rnd_link_epc", {out_link, out_epc}, {m_out.link, m_out.epc});
            chk("rnd_exc_bd", {out_exc, out_exc_code, out_bd}, {m_out.exc, m_out.code, m_out.bd});
         end
         if (m_redir) chk("rnd_target", redirect_target, m_out.target);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
